ex_mem_req_stage: RTL and testbench

- EX-stage pipeline register plus data-SRAM request issuer, sitting directly upstream of the MEM stage.
- Computes the load/store virtual address, detects misalignment (ALE) and drives the SRAM-like request channel (req/addr_ok), including store byte-enables and data replication.
- Tells MEM whether a data_ok is owed for the entry it hands over.
- On flush it finishes any request the bus has already seen and swallows orphaned data_ok responses before accepting new work.

---
 rtl/ex_mem_req_stage.sv | 124 ++++++++++++
 tb/tb_ex_mem_req_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_req_stage.sv
// ex_mem_req_stage: EX pipeline register and data-SRAM request issuer.
// Drains requests the bus has already seen, and their orphaned responses, after a flush.
module ex_mem_req_stage #(
    parameter int PAY_W = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             id_to_ex_valid,
    output logic             ex_allowin,
    input  logic             id_op_load,
    input  logic             id_op_store,
    input  logic [1:0]       id_size,
    input  logic [31:0]      id_base,
    input  logic [31:0]      id_offset,
    input  logic [31:0]      id_st_data,
    input  logic [PAY_W-1:0] id_payload,
    input  logic             mem_allowin,
    input  logic             mem_block_req,
    input  logic             mem_wait_data_ok,
    input  logic             flush,
    output logic             data_sram_req,
    output logic             data_sram_wr,
    output logic [1:0]       data_sram_size,
    output logic [3:0]       data_sram_wstrb,
    output logic [31:0]      data_sram_addr,
    output logic [31:0]      data_sram_wdata,
    input  logic             data_sram_addr_ok,
    input  logic             data_sram_data_ok,
    output logic             ex_to_mem_valid,
    output logic [31:0]      ex_to_mem_vaddr,
    output logic             ex_to_mem_ale,
    output logic             ex_to_mem_wait_data_ok,
    output logic [PAY_W-1:0] ex_to_mem_payload,
    output logic             mem_data_ok_mask
);
    typedef enum logic [1:0] {RUN, ABORT, DRAIN} state_t;
    state_t state, state_nxt;
    logic ex_valid, op_load, op_store, issued, req_seen;
    logic [1:0] size, drain_cnt, cnt_nxt;
    logic [31:0] vaddr, st_data;
    logic [PAY_W-1:0] payload;
    logic run, is_mem, ale, need_req, hit, ready_go, capture, debt;

    assign run      = state == RUN;
    assign is_mem   = op_load | op_store;
    assign ale      = is_mem & ((size == 2'd1 & vaddr[0]) | (size == 2'd2 & |vaddr[1:0]));
    assign need_req = ex_valid & is_mem & ~ale & ~issued & ~mem_block_req;
    // once the bus has seen req it stays up until addr_ok, flush or not
    assign data_sram_req = run & (need_req & ~flush | req_seen) | state == ABORT;
    assign hit      = data_sram_req & data_sram_addr_ok;
    assign ready_go = ~is_mem | ale | mem_block_req | issued | hit;
    assign ex_allowin = run & (~ex_valid | ready_go & mem_allowin);
    assign capture  = id_to_ex_valid & ex_allowin & ~flush;

    assign data_sram_wr    = op_store;
    assign data_sram_size  = size;
    assign data_sram_addr  = vaddr;
    assign data_sram_wstrb = ~op_store ? 4'b0000 :
                             size == 2'd0 ? 4'b0001 << vaddr[1:0] :
                             size == 2'd1 ? (vaddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign data_sram_wdata = size == 2'd0 ? {4{st_data[7:0]}} :
                             size == 2'd1 ? {2{st_data[15:0]}} : st_data;

    assign ex_to_mem_valid        = ex_valid & ready_go & ~flush & run;
    assign ex_to_mem_vaddr        = vaddr;
    assign ex_to_mem_ale          = ale;
    assign ex_to_mem_wait_data_ok = issued | hit;
    assign ex_to_mem_payload      = payload;
    // MEM was flushed too, so any data_ok seen outside RUN belongs to nobody
    assign mem_data_ok_mask       = ~run;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = drain_cnt;
        debt      = mem_wait_data_ok & ~data_sram_data_ok;
        if (run) begin
            if (flush & req_seen & ~data_sram_addr_ok) begin
                state_nxt = ABORT;
                cnt_nxt   = {1'b0, debt};
            end else if (flush & (issued | hit)) begin
                state_nxt = DRAIN;
                cnt_nxt   = 2'd1 + {1'b0, debt};
            end else if (flush & debt) begin
                state_nxt = DRAIN;
                cnt_nxt   = 2'd1;
            end
        end else begin
            cnt_nxt = drain_cnt + 2'(state == ABORT & data_sram_addr_ok)
                    - 2'(data_sram_data_ok & |drain_cnt);
            if (state == DRAIN | data_sram_addr_ok)
                state_nxt = cnt_nxt == 2'd0 ? RUN : DRAIN;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
            ex_valid  <= 1'b0;
            issued    <= 1'b0;
            req_seen  <= 1'b0;
            op_load   <= 1'b0;
            op_store  <= 1'b0;
            size      <= 2'd0;
            vaddr     <= 32'd0;
            st_data   <= 32'd0;
            payload   <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= cnt_nxt;
            ex_valid  <= ex_allowin ? capture : ex_valid & ~flush;
            issued    <= (flush | ex_allowin | ~run) ? 1'b0 : hit ? 1'b1 : issued;
            req_seen  <= (capture | hit) ? 1'b0 : (data_sram_req & ~data_sram_addr_ok) ? 1'b1 : req_seen;
            if (capture) begin
                op_load  <= id_op_load;
                op_store <= id_op_store;
                size     <= id_size;
                vaddr    <= id_base + id_offset;
                st_data  <= id_st_data;
                payload  <= id_payload;
            end
        end
    end
endmodule

// File: tb/tb_ex_mem_req_stage.sv
// tb_ex_mem_req_stage: directed stimulus with queued expectations for bus requests and MEM hand-offs.
module tb_ex_mem_req_stage;
    logic clk, resetn;
    logic id_to_ex_valid, ex_allowin, id_op_load, id_op_store;
    logic [1:0] id_size;
    logic [31:0] id_base, id_offset, id_st_data;
    logic [63:0] id_payload;
    logic mem_allowin, mem_block_req, mem_wait_data_ok, flush;
    logic data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0] data_sram_size;
    logic [3:0] data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic ex_to_mem_valid, ex_to_mem_ale, ex_to_mem_wait_data_ok, mem_data_ok_mask;
    logic [31:0] ex_to_mem_vaddr;
    logic [63:0] ex_to_mem_payload;

    int n_chk = 0, n_err = 0;
    bit done = 0;
    logic [70:0] req_q[$];
    logic [97:0] mem_q[$];

    ex_mem_req_stage #(.PAY_W(64)) dut (
        .clk(clk), .resetn(resetn), .id_to_ex_valid(id_to_ex_valid), .ex_allowin(ex_allowin),
        .id_op_load(id_op_load), .id_op_store(id_op_store), .id_size(id_size), .id_base(id_base),
        .id_offset(id_offset), .id_st_data(id_st_data), .id_payload(id_payload),
        .mem_allowin(mem_allowin), .mem_block_req(mem_block_req), .mem_wait_data_ok(mem_wait_data_ok),
        .flush(flush), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok), .ex_to_mem_valid(ex_to_mem_valid),
        .ex_to_mem_vaddr(ex_to_mem_vaddr), .ex_to_mem_ale(ex_to_mem_ale),
        .ex_to_mem_wait_data_ok(ex_to_mem_wait_data_ok), .ex_to_mem_payload(ex_to_mem_payload),
        .mem_data_ok_mask(mem_data_ok_mask)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #2;
        id_to_ex_valid = 0;
        data_sram_addr_ok = 0;
        data_sram_data_ok = 0;
        flush = 0;
    endtask

    task automatic present(input logic ld, input logic st, input logic [1:0] sz, input logic [31:0] b,
                           input logic [31:0] o, input logic [31:0] d, input logic [63:0] p);
        id_to_ex_valid = 1;
        id_op_load = ld;
        id_op_store = st;
        id_size = sz;
        id_base = b;
        id_offset = o;
        id_st_data = d;
        id_payload = p;
    endtask

    task automatic exp_req(input logic wr, input logic [1:0] sz, input logic [3:0] strb,
                           input logic [31:0] a, input logic [31:0] wd);
        req_q.push_back({wr, sz, strb, a, wd});
    endtask

    task automatic exp_mem(input logic [31:0] va, input logic al, input logic w, input logic [63:0] p);
        mem_q.push_back({va, al, w, p});
    endtask

    initial begin
        resetn = 0; mem_allowin = 1; mem_block_req = 0; mem_wait_data_ok = 0;
        flush = 0; data_sram_addr_ok = 0; data_sram_data_ok = 0;
        present(0, 0, 0, 0, 0, 0, 0);
        id_to_ex_valid = 0;
        fork
            begin
                #3;
                chk("rst_allowin", ex_allowin, 1);
                chk("rst_req", data_sram_req, 0);
                chk("rst_valid", ex_to_mem_valid, 0);
                chk("rst_mask", mem_data_ok_mask, 0);
                chk("rst_wait", ex_to_mem_wait_data_ok, 0);
                chk("rst_bus", {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata}, 0);
                chk("rst_mem_out", {ex_to_mem_vaddr, ex_to_mem_ale, ex_to_mem_payload}, 0);
                @(posedge clk); #2; resetn = 1;
                cyc;
                // ld.w 0x1004, addr_ok in the first request cycle
                present(1, 0, 2, 32'h1000, 32'h4, 32'hDEADBEEF, 64'hA1);
                exp_req(0, 2, 4'b0000, 32'h1004, 32'hDEADBEEF);
                exp_mem(32'h1004, 0, 1, 64'hA1);
                cyc; data_sram_addr_ok = 1; #1;
                chk("ldw_req", data_sram_req, 1);
                chk("ldw_valid", ex_to_mem_valid, 1);
                chk("ldw_wait", ex_to_mem_wait_data_ok, 1);
                cyc; #1;
                chk("ldw_req_idle", data_sram_req, 0);
                // st.b 0x2003 then st.h 0x2002 back to back
                present(0, 1, 0, 32'h2000, 32'h3, 32'h000000A5, 64'hA2);
                exp_req(1, 0, 4'b1000, 32'h2003, 32'hA5A5A5A5);
                exp_mem(32'h2003, 0, 1, 64'hA2);
                cyc; data_sram_addr_ok = 1;
                present(0, 1, 1, 32'h2000, 32'h2, 32'h1234BEEF, 64'hA3);
                exp_req(1, 1, 4'b1100, 32'h2002, 32'hBEEFBEEF);
                exp_mem(32'h2002, 0, 1, 64'hA3);
                #1; chk("stb_allowin", ex_allowin, 1);
                cyc; data_sram_addr_ok = 1;
                cyc;
                // st.w with negative offset, addr_ok one cycle late
                present(0, 1, 2, 32'h3000, 32'hFFFFFFF0, 32'hCAFEF00D, 64'hA4);
                exp_req(1, 2, 4'b1111, 32'h2FF0, 32'hCAFEF00D);
                exp_mem(32'h2FF0, 0, 1, 64'hA4);
                cyc; #1;
                chk("stw_stall_req", data_sram_req, 1);
                chk("stw_stall_valid", ex_to_mem_valid, 0);
                chk("stw_stall_allowin", ex_allowin, 0);
                cyc; data_sram_addr_ok = 1; #1;
                chk("stw_fwd", ex_to_mem_valid, 1);
                cyc;
                // misaligned ld.w: no request, exception forwarded
                present(1, 0, 2, 32'h1000, 32'h2, 32'h0, 64'hA5);
                exp_mem(32'h1002, 1, 0, 64'hA5);
                cyc; #1;
                chk("ale_no_req", data_sram_req, 0);
                chk("ale_flag", ex_to_mem_ale, 1);
                cyc;
                // ld.b at an odd address is never misaligned
                present(1, 0, 0, 32'h1000, 32'h3, 32'h77, 64'hA6);
                exp_req(0, 0, 4'b0000, 32'h1003, 32'h77777777);
                exp_mem(32'h1003, 0, 1, 64'hA6);
                cyc; data_sram_addr_ok = 1;
                cyc;
                // store flushed while req pending: ABORT, then one masked data_ok
                present(0, 1, 2, 32'h4000, 32'h8, 32'h11223344, 64'hA7);
                exp_req(1, 2, 4'b1111, 32'h4008, 32'h11223344);
                cyc; #1;
                chk("ab_req1", data_sram_req, 1);
                cyc; flush = 1; #1;
                chk("ab_flush_req", data_sram_req, 1);
                chk("ab_flush_valid", ex_to_mem_valid, 0);
                cyc; data_sram_addr_ok = 1; #1;
                chk("ab_abort_req", data_sram_req, 1);
                chk("ab_abort_allowin", ex_allowin, 0);
                cyc; present(1, 0, 2, 32'h5000, 32'h0, 32'h0, 64'hBAD); #1;
                chk("ab_drain_mask", mem_data_ok_mask, 1);
                chk("ab_drain_allowin", ex_allowin, 0);
                chk("ab_drain_req", data_sram_req, 0);
                cyc; data_sram_data_ok = 1; #1;
                chk("ab_dok_mask", mem_data_ok_mask, 1);
                cyc; #1;
                chk("ab_run_mask", mem_data_ok_mask, 0);
                chk("ab_run_allowin", ex_allowin, 1);
                // issued load stuck behind MEM, flush with MEM owed data_ok: two masked responses
                present(1, 0, 2, 32'h6000, 32'h0, 32'h0, 64'hA8);
                exp_req(0, 2, 4'b0000, 32'h6000, 32'h0);
                cyc; data_sram_addr_ok = 1; mem_allowin = 0; #1;
                chk("dr2_wait", ex_to_mem_wait_data_ok, 1);
                chk("dr2_allowin", ex_allowin, 0);
                cyc; flush = 1; mem_wait_data_ok = 1; #1;
                chk("dr2_flush_valid", ex_to_mem_valid, 0);
                chk("dr2_flush_req", data_sram_req, 0);
                cyc; mem_allowin = 1; mem_wait_data_ok = 0; data_sram_data_ok = 1; #1;
                chk("dr2_mask1", mem_data_ok_mask, 1);
                chk("dr2_allowin1", ex_allowin, 0);
                cyc; #1;
                chk("dr2_mask_gap", mem_data_ok_mask, 1);
                cyc; data_sram_data_ok = 1; #1;
                chk("dr2_mask2", mem_data_ok_mask, 1);
                cyc; #1;
                chk("dr2_run_mask", mem_data_ok_mask, 0);
                chk("dr2_run_allowin", ex_allowin, 1);
                // flush whose only debt is paid by a data_ok in the same cycle
                flush = 1; mem_wait_data_ok = 1; data_sram_data_ok = 1;
                cyc; mem_wait_data_ok = 0; #1;
                chk("same_dok_mask", mem_data_ok_mask, 0);
                chk("same_dok_allowin", ex_allowin, 1);
                // MEM blocks requests: store forwarded without touching the bus
                present(0, 1, 2, 32'h7000, 32'h0, 32'h99, 64'hA9);
                exp_mem(32'h7000, 0, 0, 64'hA9);
                cyc; mem_block_req = 1; #1;
                chk("blk_req", data_sram_req, 0);
                chk("blk_valid", ex_to_mem_valid, 1);
                cyc; mem_block_req = 0;
                // async reset in the middle of ABORT
                present(0, 1, 2, 32'h8000, 32'h0, 32'h55, 64'hAA);
                cyc; #1;
                chk("rab_req", data_sram_req, 1);
                cyc; flush = 1;
                cyc; #1;
                chk("rab_abort_req", data_sram_req, 1);
                chk("rab_abort_allowin", ex_allowin, 0);
                resetn = 0; #1;
                chk("rab_rst_req", data_sram_req, 0);
                chk("rab_rst_allowin", ex_allowin, 1);
                @(posedge clk); #2; resetn = 1;
                cyc; #1;
                chk("rab_after_allowin", ex_allowin, 1);
                chk("rab_after_req", data_sram_req, 0);
                cyc;
                chk("req_q_empty", req_q.size(), 0);
                chk("mem_q_empty", mem_q.size(), 0);
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (resetn) begin
                        if (ex_to_mem_valid && mem_allowin) begin
                            if (mem_q.size() == 0) begin
                                n_chk++; n_err++;
                                $display("FAIL mem_fwd: unexpected entry vaddr=%h", ex_to_mem_vaddr);
                            end else
                                chk("mem_fwd", {ex_to_mem_vaddr, ex_to_mem_ale, ex_to_mem_wait_data_ok,
                                                ex_to_mem_payload}, mem_q.pop_front());
                        end
                        if (data_sram_req && data_sram_addr_ok) begin
                            if (req_q.size() == 0) begin
                                n_chk++; n_err++;
                                $display("FAIL bus_req: unexpected request addr=%h", data_sram_addr);
                            end else
                                chk("bus_req", {data_sram_wr, data_sram_size, data_sram_wstrb,
                                                data_sram_addr, data_sram_wdata}, req_q.pop_front());
                        end
                    end
                end
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
